// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The master side is the fetch/decode environment; the slave side is the queue.
interface fetch_queue_if #(
  parameter int DEPTH   = 2,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
);
  logic                           in_valid;
  logic                           in_ready;
  logic [PC_W-1:0]                in_pc;
  logic [INSTR_W-1:0]             in_instr;
  logic                           out_valid;
  logic                           out_ready;
  logic [PC_W-1:0]                out_pc;
  logic [INSTR_W-1:0]             out_instr;
  logic                           flush;
  logic [$clog2(DEPTH+1)-1:0]     count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_instr, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue holding {pc, instr} pairs between fetch and decode.
// Empty queue presents a NOP; flush drops every held entry.
module fetch_queue #(
  parameter int                 DEPTH   = 2,
  parameter int                 PC_W    = 64,
  parameter int                 INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP     = 32'hD503201F
) (
  input logic          clk,
  input logic          reset,
  fetch_queue_if.slave fq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    pc_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_d [DEPTH];
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic               in_ready;
  logic               out_valid;
  logic               wr_en;
  logic               rd_en;

  always_comb begin
    in_ready    = (count_q != CNT_W'(DEPTH));
    out_valid   = (count_q != '0);
    wr_en       = fq.in_valid & in_ready;
    rd_en       = out_valid & fq.out_ready;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    // Flush wins over any concurrent read or write.
    if (fq.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) begin
        pc_mem_d[wptr_q]    = fq.in_pc;
        instr_mem_d[wptr_q] = fq.in_instr;
        wptr_d              = wptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; only valid entries are ever observed.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign fq.in_ready  = in_ready;
  assign fq.out_valid = out_valid;
  assign fq.out_pc    = out_valid ? pc_mem_q[rptr_q] : '0;
  assign fq.out_instr = out_valid ? instr_mem_q[rptr_q] : NOP;
  assign fq.count     = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected entries to a scoreboard,
// a negedge monitor pops and compares every handshake seen on the decode side.
module tb_fetch_queue;
  localparam int                 DEPTH   = 2;
  localparam int                 PC_W    = 64;
  localparam int                 INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP     = 32'hD503201F;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;
  entry_t exp_q[$];

  fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
    return 32'hE000_0000 | pc[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic [PC_W-1:0] pc, input logic push);
    fq.in_valid = v;
    fq.in_pc    = pc;
    fq.in_instr = instr_of(pc);
    if (push) exp_q.push_back({pc, instr_of(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake visible at negedge completes at the next posedge.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && !fq.flush && fq.out_valid && fq.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_pc", fq.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("mon_out_pc", fq.out_pc, e.pc);
          check("mon_out_instr", {32'h0, fq.out_instr}, {32'h0, e.instr});
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    fq.in_valid  = 1'b0;
    fq.in_pc     = '0;
    fq.in_instr  = '0;
    fq.out_ready = 1'b0;
    fq.flush     = 1'b0;
    repeat (2) step();
    reset = 1'b0;

    // Reset state
    check("rst_count", 64'(fq.count), 64'd0);
    check("rst_out_valid", 64'(fq.out_valid), 64'd0);
    check("rst_out_instr", 64'(fq.out_instr), 64'hD503201F);
    check("rst_out_pc", fq.out_pc, 64'd0);
    check("rst_in_ready", 64'(fq.in_ready), 64'd1);

    // Fill to full with decode stalled; pc=8 must be refused
    drive(1'b1, 64'd0, 1'b1);
    step();
    drive(1'b1, 64'd4, 1'b1);
    step();
    check("full_count", 64'(fq.count), 64'd2);
    check("full_in_ready", 64'(fq.in_ready), 64'd0);
    drive(1'b1, 64'd8, 1'b0);
    step();
    check("full_hold_count", 64'(fq.count), 64'd2);
    check("full_hold_out_pc", fq.out_pc, 64'd0);

    // Full + read: read only on edge1, concurrent read/write on edge2
    fq.out_ready = 1'b1;
    drive(1'b1, 64'd8, 1'b1);
    step();
    check("fr_e1_count", 64'(fq.count), 64'd1);
    check("fr_e1_out_pc", fq.out_pc, 64'd4);
    check("fr_e1_in_ready", 64'(fq.in_ready), 64'd1);
    step();
    check("fr_e2_count", 64'(fq.count), 64'd1);
    check("fr_e2_out_pc", fq.out_pc, 64'd8);
    drive(1'b0, 64'd0, 1'b0);
    step();
    check("drain_count", 64'(fq.count), 64'd0);

    // Wrap: stream 8 entries with decode always ready
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'(4 * i), 1'b1);
      step();
      check("stream_out_valid", 64'(fq.out_valid), 64'd1);
      check("stream_out_pc", fq.out_pc, 64'(4 * i));
    end
    drive(1'b0, 64'd0, 1'b0);
    step();
    check("stream_end_count", 64'(fq.count), 64'd0);

    // Flush with two held entries and a concurrent write of pc=40
    fq.out_ready = 1'b0;
    drive(1'b1, 64'd16, 1'b1);
    step();
    drive(1'b1, 64'd20, 1'b1);
    step();
    check("pre_flush_count", 64'(fq.count), 64'd2);
    drive(1'b1, 64'd40, 1'b0);
    fq.flush = 1'b1;
    step();
    fq.flush = 1'b0;
    drive(1'b0, 64'd0, 1'b0);
    exp_q.delete();
    check("flush_count", 64'(fq.count), 64'd0);
    check("flush_out_valid", 64'(fq.out_valid), 64'd0);
    check("flush_out_instr", 64'(fq.out_instr), 64'hD503201F);
    check("flush_in_ready", 64'(fq.in_ready), 64'd1);
    fq.out_ready = 1'b1;
    repeat (3) step();
    check("post_flush_out_valid", 64'(fq.out_valid), 64'd0);

    // Empty queue with write and out_ready together: no bypass
    drive(1'b1, 64'd12, 1'b1);
    #1;
    check("nobypass_out_valid", 64'(fq.out_valid), 64'd0);
    step();
    drive(1'b0, 64'd0, 1'b0);
    check("nobypass_out_pc", fq.out_pc, 64'd12);
    check("nobypass_count", 64'(fq.count), 64'd1);
    step();
    check("nobypass_drain", 64'(fq.count), 64'd0);

    // Reset mid-operation
    fq.out_ready = 1'b0;
    drive(1'b1, 64'd100, 1'b0);
    step();
    drive(1'b1, 64'd104, 1'b0);
    step();
    drive(1'b0, 64'd0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_count", 64'(fq.count), 64'd0);
    check("mid_rst_out_valid", 64'(fq.out_valid), 64'd0);
    check("mid_rst_out_pc", fq.out_pc, 64'd0);
    check("mid_rst_in_ready", 64'(fq.in_ready), 64'd1);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
